// File: rtl/rv32i_data_mem.sv
// rv32i_data_mem: byte-addressable data RAM with sized loads/stores and an MMIO counter/status block
module rv32i_data_mem #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataWe,
    input  logic        dataRe,
    input  logic [31:0] dataAddr,
    input  logic [31:0] datawData,
    input  logic [2:0]  funct3,
    output logic [31:0] rData,
    output logic        memIrq
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_cnt, store_cnt, scratch;
    logic [2:0]    status;
    logic          active, is_h, is_w, ill, mis, in_ram, in_mmio, unm;
    logic          store_ok, ram_we, mmio_we;
    logic [2:0]    err, clr;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata, word;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        active   = dataWe | dataRe;
        is_h     = funct3[1:0] == 2'b01;
        is_w     = funct3 == 3'b010;
        ill      = funct3[1:0] == 2'b11 || funct3 == 3'b110;
        mis      = (is_h & dataAddr[0]) | (is_w & |dataAddr[1:0]);
        in_ram   = dataAddr[31:AW+2] == '0;
        in_mmio  = dataAddr[31:4] == MMIO_BASE[31:4];
        // MMIO only accepts full-word accesses; anything narrower counts as unmapped
        unm      = !(in_ram | in_mmio) | (in_mmio & !is_w);
        err      = {3{active}} & {ill, unm, mis};
        store_ok = dataWe & !reset & err == 3'b000;
        ram_we   = store_ok & in_ram;
        mmio_we  = store_ok & in_mmio;
        clr      = (mmio_we && dataAddr[3:2] == 2'd2) ? datawData[2:0] : 3'b000;
        widx     = dataAddr[AW+1:2];
        be       = is_w ? 4'hF : is_h ? (dataAddr[1] ? 4'hC : 4'h3) : 4'b0001 << dataAddr[1:0];
        wdata    = is_w ? datawData : is_h ? {2{datawData[15:0]}} : {4{datawData[7:0]}};
        word     = in_ram ? mem[widx] :
                   dataAddr[3:2] == 2'd0 ? cycle_cnt :
                   dataAddr[3:2] == 2'd1 ? store_cnt :
                   dataAddr[3:2] == 2'd2 ? {29'd0, status} : scratch;
        rbyte    = word[{dataAddr[1:0], 3'b000} +: 8];
        rhalf    = dataAddr[1] ? word[31:16] : word[15:0];
        rData    = (reset | !dataRe | |err) ? 32'd0 :
                   is_w ? word :
                   is_h ? {{16{!funct3[2] & rhalf[15]}}, rhalf} :
                   {{24{!funct3[2] & rbyte[7]}}, rbyte};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we & be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            status    <= '0;
            scratch   <= '0;
            memIrq    <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ram_we) store_cnt <= store_cnt + 32'd1;
            // a new error outranks a W1C hitting the same bit
            status <= (status & ~clr) | err;
            if (mmio_we && dataAddr[3:2] == 2'd3) scratch <= datawData;
            memIrq <= |status;
        end
    end
endmodule

// File: tb/tb_rv32i_data_mem.sv
// tb_rv32i_data_mem: directed vectors with hand-computed expectations for rv32i_data_mem
module tb_rv32i_data_mem;
    logic        clk = 1'b0;
    logic        reset, dataWe, dataRe;
    logic [31:0] dataAddr, datawData, rData;
    logic [2:0]  funct3;
    logic        memIrq;
    logic [31:0] a, b;
    int          n_cmp = 0, n_err = 0;

    localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101, FBAD = 3'b011;

    rv32i_data_mem dut (
        .clk(clk), .reset(reset), .dataWe(dataWe), .dataRe(dataRe), .dataAddr(dataAddr),
        .datawData(datawData), .funct3(funct3), .rData(rData), .memIrq(memIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        @(negedge clk);
        dataWe = we; dataRe = re; dataAddr = addr; datawData = wd; funct3 = f3;
        #1;
    endtask

    task automatic ld(input logic [31:0] addr, input logic [2:0] f3);
        step(1'b0, 1'b1, addr, 32'd0, f3);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        step(1'b1, 1'b0, addr, wd, f3);
    endtask

    initial begin
        reset = 1'b1; dataWe = 1'b1; dataRe = 1'b1; dataAddr = 32'h1000; datawData = 32'd0; funct3 = FW;
        @(posedge clk); #1;
        check("rdata_in_reset", rData, 32'd0);
        check("irq_in_reset", {31'd0, memIrq}, 32'd0);
        @(negedge clk); reset = 1'b0;
        st(32'h10, 32'h1111_1111, FW);
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, FW);
        check("lw_during_sw_old", rData, 32'h1111_1111);
        ld(32'h10, FW);          check("lw_new", rData, 32'hDEAD_BEEF);
        ld(32'h1004, FW);        check("store_cnt_2", rData, 32'd2);
        st(32'h11, 32'hFFFF_FF7F, FB);
        st(32'h12, 32'hFFFF_8001, FH);
        ld(32'h10, FW);          check("lw_merged", rData, 32'h8001_7FEF);
        ld(32'h13, FB);          check("lb", rData, 32'hFFFF_FF80);
        ld(32'h13, FBU);         check("lbu", rData, 32'h0000_0080);
        ld(32'h12, FH);          check("lh", rData, 32'hFFFF_8001);
        ld(32'h12, FHU);         check("lhu", rData, 32'h0000_8001);
        ld(32'h11, FB);          check("lb_pos", rData, 32'h0000_007F);
        st(32'h20, 32'h1234_5678, FW);
        st(32'h22, 32'h0000_0055, FW);
        ld(32'h1008, FW);        check("status_mis", rData, 32'h1);
        check("irq_lag", {31'd0, memIrq}, 32'd0);
        ld(32'h20, FW);          check("ram_after_mis", rData, 32'h1234_5678);
        check("irq_set", {31'd0, memIrq}, 32'd1);
        ld(32'h1004, FW);        check("store_cnt_5", rData, 32'd5);
        st(32'h1008, 32'h1, FW);
        ld(32'h1008, FW);        check("status_w1c", rData, 32'h0);
        check("irq_still", {31'd0, memIrq}, 32'd1);
        ld(32'h10, FW);
        check("irq_clear", {31'd0, memIrq}, 32'd0);
        ld(32'h2000, FW);        check("lw_unmapped", rData, 32'd0);
        ld(32'h1008, FW);        check("status_unm", rData, 32'h2);
        st(32'h100C, 32'hCAFE_F00D, FW);
        st(32'h100C, 32'h0000_00AA, FB);
        ld(32'h100C, FW);        check("scratch_kept", rData, 32'hCAFE_F00D);
        st(32'h10, 32'h0, FBAD);
        ld(32'h1008, FW);        check("status_ill", rData, 32'h6);
        ld(32'h10, FW);          check("ram_after_ill", rData, 32'h8001_7FEF);
        step(1'b1, 1'b1, 32'h1008, 32'h2, FBAD);
        check("rdata_err_both", rData, 32'd0);
        ld(32'h1008, FW);        check("status_set_wins", rData, 32'h6);
        st(32'h1008, 32'h7, FW);
        ld(32'h1008, FW);        check("status_all_clr", rData, 32'h0);
        ld(32'h1004, FW);        check("store_cnt_mmio", rData, 32'd5);
        ld(32'h1000, FW);        a = rData;
        repeat (4) ld(32'h10, FW);
        ld(32'h1000, FW);        b = rData;
        check("cycle_delta", b - a, 32'd5);
        ld(32'h11, FH);          check("lh_mis", rData, 32'd0);
        ld(32'h10, FW);
        ld(32'h10, FW);          check("irq_before_reset", {31'd0, memIrq}, 32'd1);
        @(negedge clk);
        reset = 1'b1; dataWe = 1'b1; dataRe = 1'b1; dataAddr = 32'h10; datawData = 32'd0; funct3 = FW;
        #1; check("rdata_reset", rData, 32'd0);
        @(negedge clk); reset = 1'b0; dataWe = 1'b0; dataAddr = 32'h1000; #1;
        check("cycle_after_reset", rData, 32'd0);
        check("irq_after_reset", {31'd0, memIrq}, 32'd0);
        ld(32'h1004, FW);        check("store_cnt_reset", rData, 32'd0);
        ld(32'h1008, FW);        check("status_reset", rData, 32'd0);
        ld(32'h100C, FW);        check("scratch_reset", rData, 32'd0);
        ld(32'h10, FW);          check("ram_retained", rData, 32'h8001_7FEF);
        ld(32'h1000, FW);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt;
        #1 check("cycle_forced", rData, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("cycle_wrap", rData, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv32i_data_mem.md
Name: rv32i_data_mem

Overview:
- Data-side responder for the RV32I core: accepts the core's store/load requests (write enable, address, write data, access size) and returns load data.
- Contains a byte-addressable data RAM, sized store/load handling with sign/zero extension, and a small memory-mapped status/counter block.
- Sits between the core's data port and the top level, opposite the core's data-request outputs.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words. Must be a power of two. RAM occupies byte addresses 0 to DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h0000_1000, base byte address of the 4-word register block.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- dataWe  input  1  store request this cycle
- dataRe  input  1  load request this cycle
- dataAddr  input  32  byte address
- datawData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rData  output  32  load data, combinational, extended per funct3
- memIrq  output  1  registered; equals OR of the status bits

Behaviour:
- Reset: one clk with reset high.
  - Cycle counter, store counter, status and scratch registers clear to 0.
  - memIrq = 0; rData = 0 while reset is high.
  - Stores are suppressed while reset is high.
  - RAM contents are not cleared.
- Writes commit at the rising edge. Reads are combinational from current state.
  - A load in the same cycle as a store to the same address returns the old data.
  - The next cycle returns the new data.
- Stores: only the addressed bytes are written.
  - SB writes byte dataAddr[1:0] from datawData[7:0].
  - SH writes bytes 2*dataAddr[1] and 2*dataAddr[1]+1 from datawData[15:0].
  - SW writes all four bytes.
- Loads:
  - LB/LH: selected byte or half, sign-extended.
  - LBU/LHU: selected byte or half, zero-extended.
  - LW: full word.
- Error rules (checked only when dataWe or dataRe is 1):
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 → status bit0.
  - Unmapped: address outside RAM and outside MMIO_BASE..MMIO_BASE+15, or non-word access to MMIO → status bit1.
  - Illegal size: funct3 = 011, 110 or 111 → status bit2.
  - Any error: store suppressed (no RAM/register change, store counter not incremented); rData = 0.
  - If dataWe and dataRe are both 1, the store is performed and rData is still driven.
- MMIO registers (word access only):
  - +0x0 cycle counter: read-only, increments every non-reset cycle, wraps FFFF_FFFF → 0.
  - +0x4 store counter: read-only, +1 per committed RAM store (not MMIO stores), wraps.
  - +0x8 status [2:0]: sticky. A store clears the bits written as 1 (W1C). If a new error and a clear hit the same bit in the same cycle, set wins.
  - +0xC scratch: read/write.
  - Stores to read-only registers are ignored with no error.
- memIrq updates one cycle after a status change.
- Unused status bits [31:3] read as 0.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 → 0xDEADBEEF. Same-cycle LW during the SW → prior contents. Store counter reads 1.
- SB 0x7F to 0x11, SH 0x8001 to 0x12 over the above word → LW 0x10 = 0x80017FEF. LB 0x13 = 0xFFFFFF80. LBU 0x13 = 0x00000080. LH 0x12 = 0xFFFF8001. LHU 0x12 = 0x00008001.
- SW to 0x22 (misaligned) → RAM unchanged, status = 0x1, memIrq = 1 next cycle, store counter unchanged. SW 0x1 to 0x1008 → status 0, memIrq 0 the following cycle.
- LW at 0x2000 (unmapped) → rData = 0, status bit1. SB to 0x100C → status bit1, scratch unchanged. funct3 = 011 store → status bit2. A W1C of bit1 in the same cycle as a new unmapped access → bit1 stays 1.
- Cycle counter:
  - Read 0x1000 twice, N cycles apart → difference N.
  - Assert reset for 1 cycle → cycle counter, store counter, status and scratch all 0, while previously written RAM data is retained.
  - Force the counter to FFFF_FFFF in simulation → next value 0.
